// File: rtl/updown_counter_mod.sv
// Modulo-MODULUS up/down counter with synchronous load, wrap pulse and active-low 7-segment hex decode.
// Optional feature macro: COUNTER_PRESCALE_EN (adds a PRESCALE-cycle step prescaler).
module updown_counter_mod #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int PRESCALE = 4
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             iEn,
  input  logic             iUp,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iData,
  output logic [WIDTH-1:0] oQ,
  output logic             oWrap,
  output logic [6:0]       oDisplay
);

  localparam logic [WIDTH-1:0] MAXV    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic             tick;
  logic             loadInRange;
  logic [WIDTH-1:0] loadValue;
  logic [3:0]       nibble;

  // Extra top bit keeps the range check exact when MODULUS equals 2^WIDTH
  assign loadInRange = ({1'b0, iData} < MOD_EXT);
  assign loadValue   = loadInRange ? iData : '0;

`ifdef COUNTER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] prescaler;

  assign tick = (prescaler == PW'(PRESCALE - 1));

  always_ff @(posedge CLK) begin
    if (rst || iLoad) begin
      prescaler <= '0;
    end else if (iEn) begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
    end
  end
`else
  // Always true for any legal PRESCALE; an illegal zero simply stalls counting
  assign tick = (PRESCALE >= 1);
`endif

  always_ff @(posedge CLK) begin
    if (rst) begin
      oQ    <= '0;
      oWrap <= 1'b0;
    end else if (iLoad) begin
      oQ    <= loadValue;
      oWrap <= 1'b0;
    end else if (iEn && tick) begin
      if (iUp) begin
        if (oQ == MAXV) begin
          oQ    <= '0;
          oWrap <= 1'b1;
        end else begin
          oQ    <= oQ + WIDTH'(1);
          oWrap <= 1'b0;
        end
      end else begin
        if (oQ == '0) begin
          oQ    <= MAXV;
          oWrap <= 1'b1;
        end else begin
          oQ    <= oQ - WIDTH'(1);
          oWrap <= 1'b0;
        end
      end
    end else begin
      oWrap <= 1'b0;
    end
  end

  generate
    if (WIDTH >= 4) begin : g_nibble_wide
      assign nibble = oQ[3:0];
    end else begin : g_nibble_narrow
      assign nibble = {{(4 - WIDTH){1'b0}}, oQ};
    end
  endgenerate

  // Segment order {g,f,e,d,c,b,a}; a zero bit lights the segment
  always_comb begin
    oDisplay = 7'b1111111;
    case (nibble)
      4'h0: oDisplay = 7'b1000000;
      4'h1: oDisplay = 7'b1111001;
      4'h2: oDisplay = 7'b0100100;
      4'h3: oDisplay = 7'b0110000;
      4'h4: oDisplay = 7'b0011001;
      4'h5: oDisplay = 7'b0010010;
      4'h6: oDisplay = 7'b0000010;
      4'h7: oDisplay = 7'b1111000;
      4'h8: oDisplay = 7'b0000000;
      4'h9: oDisplay = 7'b0010000;
      4'hA: oDisplay = 7'b0001000;
      4'hB: oDisplay = 7'b0000011;
      4'hC: oDisplay = 7'b1000110;
      4'hD: oDisplay = 7'b0100001;
      4'hE: oDisplay = 7'b0000110;
      4'hF: oDisplay = 7'b0001110;
      default: oDisplay = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed self-checking bench for updown_counter_mod: mod-10, mod-16 and 1-bit mod-2 instances share stimulus.
// With COUNTER_PRESCALE_EN defined, an extra PRESCALE=4 instance is exercised as well.
module tb_updown_counter_mod;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, up, load;
  logic [3:0] data;
  logic       data1;

  logic [3:0] q10, q16;
  logic       w10, w16, q2, w2;
  logic [6:0] d10, d16, d2;

  int errorCount = 0;
  int checkCount = 0;

  logic [6:0] seg [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  updown_counter_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut10 (
    .CLK(clk), .rst(rst), .iEn(en), .iUp(up), .iLoad(load), .iData(data),
    .oQ(q10), .oWrap(w10), .oDisplay(d10));

  updown_counter_mod #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) dut16 (
    .CLK(clk), .rst(rst), .iEn(en), .iUp(up), .iLoad(load), .iData(data),
    .oQ(q16), .oWrap(w16), .oDisplay(d16));

  updown_counter_mod #(.WIDTH(1), .MODULUS(2), .PRESCALE(1)) dut2 (
    .CLK(clk), .rst(rst), .iEn(en), .iUp(up), .iLoad(load), .iData(data1),
    .oQ(q2), .oWrap(w2), .oDisplay(d2));

`ifdef COUNTER_PRESCALE_EN
  logic [3:0] qp;
  logic       wp;
  logic [6:0] dp;

  updown_counter_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(4)) dutp (
    .CLK(clk), .rst(rst), .iEn(en), .iUp(up), .iLoad(load), .iData(data),
    .oQ(qp), .oWrap(wp), .oDisplay(dp));
`endif

  task automatic applyStimulus(input logic r, input logic e, input logic u,
                               input logic l, input logic [3:0] d);
    rst   = r;
    en    = e;
    up    = u;
    load  = l;
    data  = d;
    data1 = d[0];
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  initial begin
    // Reset, count a little, then reset during counting for two cycles
    applyStimulus(1, 0, 1, 0, 4'd0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 4'd0);
    checkOutput("pre_reset_q", 16'(q10), 16'd3);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 1, 1, 0, 4'd0);
      checkOutput("reset_q", 16'(q10), 16'd0);
      checkOutput("reset_wrap", 16'(w10), 16'd0);
      checkOutput("reset_disp", 16'(d10), 16'h40);
    end
    applyStimulus(0, 1, 1, 0, 4'd0);
    checkOutput("post_reset_step", 16'(q10), 16'd1);

    // Sixteen up steps from zero on all instances
    applyStimulus(1, 0, 1, 0, 4'd0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 1, 1, 0, 4'd0);
      checkOutput("up10_q", 16'(q10), 16'((i + 1) % 10));
      checkOutput("up10_wrap", 16'(w10), 16'(i == 9));
      checkOutput("up10_disp", 16'(d10), 16'(seg[(i + 1) % 10]));
      checkOutput("up16_q", 16'(q16), 16'((i + 1) % 16));
      checkOutput("up16_wrap", 16'(w16), 16'(i == 15));
      checkOutput("up16_disp", 16'(d16), 16'(seg[(i + 1) % 16]));
      checkOutput("up2_q", 16'(q2), 16'((i + 1) % 2));
      checkOutput("up2_wrap", 16'(w2), 16'((i % 2) == 1));
      checkOutput("up2_disp", 16'(d2), ((i % 2) == 0) ? 16'h79 : 16'h40);
    end

    // Load 2, count down through the wrap, then turn around
    applyStimulus(0, 0, 0, 1, 4'd2);
    checkOutput("load2_q", 16'(q10), 16'd2);
    applyStimulus(0, 1, 0, 0, 4'd0);
    checkOutput("down_q1", 16'(q10), 16'd1);
    applyStimulus(0, 1, 0, 0, 4'd0);
    checkOutput("down_q0", 16'(q10), 16'd0);
    checkOutput("down_nowrap", 16'(w10), 16'd0);
    applyStimulus(0, 1, 0, 0, 4'd0);
    checkOutput("down_q9", 16'(q10), 16'd9);
    checkOutput("down_wrap", 16'(w10), 16'd1);
    applyStimulus(0, 1, 0, 0, 4'd0);
    checkOutput("down_q8", 16'(q10), 16'd8);
    checkOutput("down_wrap_clr", 16'(w10), 16'd0);
    applyStimulus(0, 1, 1, 0, 4'd0);
    checkOutput("turn_up_q9", 16'(q10), 16'd9);
    applyStimulus(0, 0, 1, 0, 4'd0);
    checkOutput("hold_q", 16'(q10), 16'd9);
    checkOutput("hold_wrap", 16'(w10), 16'd0);

    // Load beats a step that would otherwise wrap; out-of-range loads clamp to zero
    applyStimulus(0, 1, 1, 1, 4'd7);
    checkOutput("load_en_q", 16'(q10), 16'd7);
    checkOutput("load_en_wrap", 16'(w10), 16'd0);
    applyStimulus(0, 1, 1, 1, 4'd12);
    checkOutput("load12_q10", 16'(q10), 16'd0);
    checkOutput("load12_q16", 16'(q16), 16'd12);
    checkOutput("load12_disp16", 16'(d16), 16'h46);
    applyStimulus(0, 0, 1, 1, 4'd10);
    checkOutput("load10_q", 16'(q10), 16'd0);
    applyStimulus(0, 0, 1, 1, 4'd9);
    checkOutput("load9_q", 16'(q10), 16'd9);
    applyStimulus(1, 1, 1, 1, 4'd5);
    checkOutput("rst_over_load", 16'(q10), 16'd0);

`ifdef COUNTER_PRESCALE_EN
    // Prescale by four: steps land on every fourth enabled cycle
    applyStimulus(1, 0, 1, 0, 4'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 1, 0, 4'd0);
      checkOutput("pre_q", 16'(qp), 16'((i + 1) / 4));
    end
    // Two enabled, three idle, then two enabled: step on the fourth enabled cycle
    applyStimulus(1, 0, 1, 0, 4'd0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 1, 0, 4'd0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 4'd0);
    applyStimulus(0, 1, 1, 0, 4'd0);
    checkOutput("pre_gap_q0", 16'(qp), 16'd0);
    applyStimulus(0, 1, 1, 0, 4'd0);
    checkOutput("pre_gap_q1", 16'(qp), 16'd1);
    // Load mid-prescale restarts the four-cycle window
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 1, 0, 4'd0);
    applyStimulus(0, 1, 1, 1, 4'd5);
    checkOutput("pre_load_q", 16'(qp), 16'd5);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 4'd0);
    checkOutput("pre_load_hold", 16'(qp), 16'd5);
    applyStimulus(0, 1, 1, 0, 4'd0);
    checkOutput("pre_load_step", 16'(qp), 16'd6);
`endif

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/updown_counter_mod.md
# updown_counter_mod

Parametrised modulo-N up/down counter with synchronous load, wrap pulse and 7-segment hex output. It is the general-purpose successor to the fixed 3-bit JK-based counter. It drives a single seven-segment digit directly, and can be cascaded through `oWrap` to form multi-digit counters. All state is in flip-flops clocked by `CLK`. The display path is purely combinational from `oQ`.

## Interface
Parameters:
- `WIDTH`, default 4: counter width in bits; legal range 1..16.
- `MODULUS`, default 10: count range 0..MODULUS-1; legal range 2..2^WIDTH.
- `PRESCALE`, default 4: enabled cycles per count step; legal range ≥1. Only used with `COUNTER_PRESCALE_EN`.

Ports:
- `CLK` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `iEn` input 1: count enable.
- `iUp` input 1: direction; 1 = up, 0 = down.
- `iLoad` input 1: synchronous load of `iData`.
- `iData` input WIDTH: load value.
- `oQ` output WIDTH: registered count value.
- `oWrap` output 1: registered one-cycle pulse, asserted the cycle after a wrap step.
- `oDisplay` output 7: segments {g,f,e,d,c,b,a}, active-low, decoded from `oQ`.

## Operation
- Priority per rising edge is `rst` > `iLoad` > count step.
- `rst`:
  - `oQ` ← 0, `oWrap` ← 0, prescaler ← 0.
  - `oDisplay` therefore shows "0" (7'b1000000).
- `iLoad`:
  - `oQ` ← `iData` if `iData` < MODULUS, otherwise `oQ` ← 0.
  - `oWrap` ← 0; prescaler ← 0.
  - Load takes effect regardless of `iEn`.
- Step condition: `iEn` = 1 and the prescaler tick is active (see Configuration).
- Up step: `oQ` = MODULUS-1 → 0 with `oWrap` ← 1; otherwise `oQ` + 1.
- Down step: `oQ` = 0 → MODULUS-1 with `oWrap` ← 1; otherwise `oQ` − 1.
- No step: `oQ` holds, `oWrap` ← 0.
- `iUp` is sampled only on step cycles; changing direction mid-count is legal and takes effect on the next step.
- Arithmetic: `oQ` never leaves 0..MODULUS-1. When MODULUS = 2^WIDTH, wrap is the natural roll-over, but `oWrap` is still generated.
- Display decode:
  - Input is `oQ[3:0]`, zero-extended when WIDTH < 4; bits above 3 are ignored.
  - Encodes hex 0–9 and A, b, C, d, E, F.

## Timing
- Latency: a qualifying step/load/reset edge updates `oQ` on that same edge; visible one cycle after the inputs are sampled.
- `oWrap` is high for exactly one cycle, coincident with the new wrapped `oQ` value.
- Back-to-back wraps (MODULUS = 2, continuous up steps) produce `oWrap` high on alternate cycles.
- Cascading: feed the low digit's `oWrap` into the next digit's `iEn`. The upper digit advances one cycle after the lower digit wraps; the skew is accepted.
- `iLoad` and `iEn` asserted in the same cycle: load wins, and no `oWrap` is generated.
- `rst` mid-count or mid-prescale: all state clears on that edge; counting resumes on the first step after `rst` falls.
- `oDisplay` is valid combinationally within the same cycle as `oQ`; it has no added latency.

## Configuration
- Macro: `COUNTER_PRESCALE_EN`.
- Defined:
  - Adds an internal prescaler of ceil(log2(PRESCALE)) bits.
  - The prescaler counts cycles with `iEn` = 1, from 0 to PRESCALE-1.
  - The tick is active on the cycle the prescaler equals PRESCALE-1; the prescaler returns to 0 on that cycle.
  - Cycles with `iEn` = 0 freeze the prescaler.
  - Result: `oQ` advances once per PRESCALE enabled cycles.
- Undefined:
  - No prescaler logic; the tick is constant 1, so `oQ` steps on every `iEn` cycle.
  - The `PRESCALE` parameter is ignored.

## Test plan
- Reset: with WIDTH=4, MODULUS=10, hold `rst` for 2 cycles during counting → `oQ`=0, `oWrap`=0, `oDisplay`=7'b1000000. The first step after release → `oQ`=1.
- Up wrap: `iUp`=1, `iEn`=1 for 12 cycles from 0 → `oQ` runs 1..9, 0, 1, 2; `oWrap` is high only while `oQ` transitions 9→0.
- Down wrap and direction change: load 2, `iUp`=0 for 4 steps → `oQ` 1, 0, 9, 8 with `oWrap` on 0→9. Then set `iUp`=1 → `oQ` 9.
- Load priority and clamping:
  - `iLoad`=1, `iEn`=1, `iData`=7 → `oQ`=7, no `oWrap`.
  - `iData`=12 → `oQ`=0.
- Hex display and full range: WIDTH=4, MODULUS=16, count up → `oDisplay` shows each of 0–F once; `oWrap` fires on F→0.
- Prescaler, with `COUNTER_PRESCALE_EN` and PRESCALE=4:
  - 8 enabled cycles → `oQ`=2.
  - Insert 3 `iEn`=0 cycles mid-sequence → step timing shifts by exactly 3 cycles.
  - `iLoad` mid-prescale → the next step occurs 4 enabled cycles later.
